packet_inject: RTL

PACKET_INJECT -- requirements
Module: packet_inject

---
 rtl/packet_inject_if.sv | 30 +++
 rtl/packet_inject.sv | 138 +++++++++++++
 2 files changed

// File: rtl/packet_inject_if.sv
// Host, trigger, live-stream and merged-stream signals for packet_inject.
// master drives the buffer writes, trigger and live stream; slave is the injector.
interface packet_inject_if #(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned ADDRWIDTH = 5
);
  logic                 we;
  logic [ADDRWIDTH-1:0] wr_addr;
  logic [DATAWIDTH-1:0] wr_data;
  logic [ADDRWIDTH-1:0] pkt_last;
  logic                 trig;
  logic                 busy;
  logic [DATAWIDTH-1:0] live_data_in;
  logic                 live_sot_in;
  logic                 live_eot_in;
  logic [DATAWIDTH-1:0] sample_data_out;
  logic                 sample_sot_out;
  logic                 sample_eot_out;
  logic [7:0]           drop_cnt;

  modport master (
    output we, wr_addr, wr_data, pkt_last, trig, live_data_in, live_sot_in, live_eot_in,
    input  busy, sample_data_out, sample_sot_out, sample_eot_out, drop_cnt
  );

  modport slave (
    input  we, wr_addr, wr_data, pkt_last, trig, live_data_in, live_sot_in, live_eot_in,
    output busy, sample_data_out, sample_sot_out, sample_eot_out, drop_cnt
  );
endinterface

// File: rtl/packet_inject.sv
// Injects a host-loaded packet into a live sample stream between live packets.
// Define INJECT_LOOP_EN to keep reinjecting while trig stays high (default: one-shot).
module packet_inject #(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned ADDRWIDTH = 5
) (
  input logic             clk,
  input logic             reset_l,
  packet_inject_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StWaitGap, StPlay} state_e;

  state_e               state_q, state_d;
  logic                 trig_q;
  logic                 rise, fall;
  logic                 live_in_pkt_q, live_in_pkt_d;
  logic                 dropping_q, dropping_d;
  logic [ADDRWIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDRWIDTH-1:0] len_q, len_d;
  logic [DATAWIDTH-1:0] mem [2**ADDRWIDTH];
  logic [DATAWIDTH-1:0] rd_data_q;
  logic                 rd_vld_q, rd_sot_q, rd_eot_q;
  logic                 play_start, play_end, supp, drop_now;
  logic [7:0]           drop_cnt_q, drop_cnt_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic                 sot_q, sot_d, eot_q, eot_d;

  assign rise = bus.trig & ~trig_q;
  assign fall = ~bus.trig & trig_q;

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    len_d      = len_q;
    play_start = 1'b0;
    play_end   = 1'b0;
    unique case (state_q)
      StIdle: if (rise) state_d = StWaitGap;
      StWaitGap: begin
        if (fall) begin
          state_d = StIdle;
        end else if (!live_in_pkt_q && !bus.live_sot_in) begin
          state_d    = StPlay;
          rd_addr_d  = '0;
          len_d      = bus.pkt_last;
          play_start = 1'b1;
        end
      end
      StPlay: begin
        if (rd_addr_q == len_q) begin
          play_end  = 1'b1;
          rd_addr_d = '0;
`ifdef INJECT_LOOP_EN
          state_d   = bus.trig ? StWaitGap : StIdle;
`else
          state_d   = StIdle;
`endif
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Window spans the PLAY-entry edge through the edge that emits the injected eot.
  assign supp     = play_start | (state_q == StPlay) | rd_vld_q;
  assign drop_now = dropping_q | (supp & bus.live_sot_in);

  always_comb begin
    live_in_pkt_d = live_in_pkt_q;
    if (bus.live_eot_in)      live_in_pkt_d = 1'b0;
    else if (bus.live_sot_in) live_in_pkt_d = 1'b1;

    dropping_d = drop_now & ~bus.live_eot_in;
    drop_cnt_d = drop_cnt_q;
    if (supp && bus.live_sot_in && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;

    data_d = '0;
    sot_d  = 1'b0;
    eot_d  = 1'b0;
    if (rd_vld_q) begin
      data_d = rd_data_q;
      sot_d  = rd_sot_q;
      eot_d  = rd_eot_q;
    end else if (!supp && !drop_now) begin
      data_d = bus.live_data_in;
      sot_d  = bus.live_sot_in;
      eot_d  = bus.live_eot_in;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.we) mem[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q       <= StIdle;
      trig_q        <= 1'b0;
      live_in_pkt_q <= 1'b0;
      dropping_q    <= 1'b0;
      rd_addr_q     <= '0;
      len_q         <= '0;
      rd_data_q     <= '0;
      rd_vld_q      <= 1'b0;
      rd_sot_q      <= 1'b0;
      rd_eot_q      <= 1'b0;
      drop_cnt_q    <= '0;
      data_q        <= '0;
      sot_q         <= 1'b0;
      eot_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      trig_q        <= bus.trig;
      live_in_pkt_q <= live_in_pkt_d;
      dropping_q    <= dropping_d;
      rd_addr_q     <= rd_addr_d;
      len_q         <= len_d;
      rd_data_q     <= mem[rd_addr_q];
      rd_vld_q      <= (state_q == StPlay);
      rd_sot_q      <= (state_q == StPlay) && (rd_addr_q == '0);
      rd_eot_q      <= play_end;
      drop_cnt_q    <= drop_cnt_d;
      data_q        <= data_d;
      sot_q         <= sot_d;
      eot_q         <= eot_d;
    end
  end

  assign bus.busy            = (state_q != StIdle);
  assign bus.drop_cnt        = drop_cnt_q;
  assign bus.sample_data_out = data_q;
  assign bus.sample_sot_out  = sot_q;
  assign bus.sample_eot_out  = eot_q;

endmodule
